serial_alu_ctrl: RTL and testbench
==================================

# serial_alu_ctrl

Bit-serial ALU sequencer that computes a WIDTH-bit arithmetic result one bit per clock. Each cycle it runs a single 1-bit arithmetic element (`ae1`) and a registered full-adder carry. It sits beside the ALU datapath as the low-area alternative to the parallel ALU. It owns operand/result shift registers, the carry flop, the sequencing FSM and the start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width in bits; legal range 2..32.

Ports:
- `clk`, input, 1, single system clock; all state changes on rising edge.
- `rst`, input, 1, asynchronous, active-high reset.
- `start`, input, 1, request; sampled only in IDLE.
- `m`, input, 1, arithmetic-element mode; 0 forces the B-side operand to 0.
- `s`, input, 2, arithmetic-element select.
- `cin`, input, 1, carry into bit 0.
- `a`, input, WIDTH, operand A.
- `b`, input, WIDTH, operand B.
- `busy`, output, 1, high while an operation is in progress.
- `done`, output, 1, one-cycle pulse when `result` and flags update.
- `result`, output, WIDTH, last completed result; held until the next completion.
- `cout`, output, 1, carry out of bit WIDTH-1.
- `zero`, output, 1, `result` == 0.
- `ovf`, output, 1, signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Per-bit B-side operand Y = m & ((~s[1] & b_k) | (~s[0] & ~b_k)).
- With m=1: s=00 gives Y=1 (A + all-ones + cin), s=01 gives Y=b (add), s=10 gives Y=~b (subtract when cin=1), s=11 gives Y=0 (pass/increment A).
- With m=0: Y=0 for every s.
- Sum bit: a_k ^ Y ^ c. Carry register update: c <= maj(a_k, Y, c).
- FSM states: IDLE, SHIFT.
  - IDLE & start: latch `a`, `b`, `m`, `s` into internal registers, load c <= cin, clear bit counter, go to SHIFT.
  - SHIFT: process LSB of the A/B shift registers, shift the sum bit into the MSB end of the accumulator, increment the counter.
  - SHIFT on the last bit (counter == WIDTH-1): copy the accumulator to `result`, set `cout`, `zero` and `ovf`, pulse `done`, go to IDLE.
- `ovf` uses the carry register value entering the MSB cycle, which is retained in a 1-bit flop.
- Inputs `a`, `b`, `m`, `s` and `cin` are ignored outside the accept cycle, so changing them mid-operation has no effect.
- `start` in SHIFT is ignored. It is not queued.
- `start` held continuously produces back-to-back operations, each WIDTH+1 cycles apart including the IDLE accept cycle.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, cout=0, zero=1, ovf=0, all internal registers 0.
- Reset mid-operation aborts the operation. No `done` is produced, and outputs take their reset values immediately.
- Edge E0, start accepted: `busy` is 1 from after E0.
- Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- At edge E_WIDTH: `result` and flags update, `done`=1 for exactly one cycle, `busy`=0.
- Start-to-done latency is WIDTH cycles. The next start is accepted at E_WIDTH+1 at the earliest.
- `done` and `busy` are never high together.
- `result` and flags are stable except at a done edge or reset.

## Structure
- Shared package `alu_pkg` holds:
  - FSM state encodings (IDLE, SHIFT).
  - Named constants for the s encodings: AE_ONES=2'b00, AE_B=2'b01, AE_NB=2'b10, AE_ZERO=2'b11.
- Sub-module: one instance of the existing `ae1` generates Y from the registered m, s and the current b bit.
- The full adder, shift registers, counter (width $clog2(WIDTH)) and FSM are inline.

## Test plan
All scenarios use WIDTH=8.
- Add: reset, then start with a=0x3C, b=0x0F, m=1, s=01, cin=0.
  - Expect `done` exactly 8 cycles after the accept edge.
  - Expect result=0x4B, cout=0, ovf=0, zero=0.
  - Expect `busy` high throughout.
- Subtract: a=0x10, b=0x20, m=1, s=10, cin=1 -> result=0xF0, cout=0, ovf=0.
  - Then a=0x80, b=0x01 -> result=0x7F, cout=1, ovf=1.
- Overflow and zero: a=0x7F, b=0x01, s=01, cin=0 -> result=0x80, ovf=1, cout=0.
  - Then a=0x01, b=0xFF -> result=0x00, cout=1, zero=1, ovf=0.
- Constant modes:
  - s=00, a=0x00, cin=0 -> 0xFF.
  - s=11, a=0xFF, cin=1 -> 0x00 with cout=1.
  - m=0, s=01, a=0x55, b=0xAA -> 0x55.
- Handshake: hold `start` high for 20 cycles.
  - Expect two completed operations, with done pulses 9 cycles apart.
  - `start` pulses during SHIFT are ignored.
  - Changing `a` mid-operation does not alter the result.
- Reset mid-operation: assert `rst` at bit 4 of an add.
  - Expect busy=0, result=0, zero=1 without waiting for a clock edge, and no `done`.
  - A subsequent operation completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the serial ALU: sequencer states and arithmetic-element select codes.
package alu_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [1:0] AE_ONES = 2'b00;
   localparam logic [1:0] AE_B    = 2'b01;
   localparam logic [1:0] AE_NB   = 2'b10;
   localparam logic [1:0] AE_ZERO = 2'b11;

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Operand/result bundle between a requester and the bit-serial ALU; start is a level request,
// done a one-cycle completion pulse.
interface serial_alu_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             m;
   logic [1:0]       s;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             zero;
   logic             ovf;

   modport master (
      output start, m, s, cin, a, b,
      input  busy, done, result, cout, zero, ovf
   );

   modport slave (
      input  start, m, s, cin, a, b,
      output busy, done, result, cout, zero, ovf
   );
endinterface

// File: rtl/ae1.sv
// 1-bit arithmetic element: selects the B-side adder operand; purely combinational, no backpressure.
module ae1 (
   input  logic       m,
   input  logic [1:0] s,
   input  logic       b,
   output logic       y
);
   assign y = m & ((~s[1] & b) | (~s[0] & ~b));
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: WIDTH cycles from accept to done, one bit per clock.
// Busy blocks new requests; start is only sampled in IDLE and never queued.
module serial_alu_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   serial_alu_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   state_t           state, state_nxt;
   logic             accept, shift_en, last;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, res_r;
   logic             m_r;
   logic [1:0]       s_r;
   logic             c, c_msb, cout_r, zero_r, done_r;
   logic             y, sum, carry;

   ae1 u_ae1 (
      .m (m_r),
      .s (s_r),
      .b (b_sh[0]),
      .y (y)
   );

   assign sum     = a_sh[0] ^ y ^ c;
   assign carry   = (a_sh[0] & y) | (a_sh[0] & c) | (y & c);
   assign last    = (cnt == CW'(WIDTH - 1));
   assign acc_nxt = {sum, acc[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      shift_en  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         res_r  <= '0;
         m_r    <= 1'b0;
         s_r    <= 2'b00;
         c      <= 1'b0;
         c_msb  <= 1'b0;
         cout_r <= 1'b0;
         zero_r <= 1'b1;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            m_r  <= bus.m;
            s_r  <= bus.s;
            c    <= bus.cin;
            cnt  <= '0;
         end else if (shift_en) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= acc_nxt;
            c    <= carry;
            cnt  <= cnt + CW'(1);
            // The carry entering the MSB is kept so ovf can be derived from the held flags.
            if (last) begin
               res_r  <= acc_nxt;
               cout_r <= carry;
               c_msb  <= c;
               zero_r <= (acc_nxt == '0);
               done_r <= 1'b1;
            end
         end
      end
   end

   assign bus.busy   = (state == SHIFT);
   assign bus.done   = done_r;
   assign bus.result = res_r;
   assign bus.cout   = cout_r;
   assign bus.zero   = zero_r;
   assign bus.ovf    = c_msb ^ cout_r;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl at WIDTH=8: vector table, random ops vs a word-level model,
// and handshake / mid-operation reset sequences.
module tb_serial_alu_ctrl;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   serial_alu_ctrl_if #(.WIDTH(8)) bus ();

   serial_alu_ctrl #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [7:0] r;
      logic       c;
      logic       z;
      logic       o;
   } res_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       m;
      logic [1:0] s;
      logic       cin;
      logic [7:0] er;
      logic       ec;
      logic       ez;
      logic       eo;
   } vec_t;

   function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic m,
                                  input logic [1:0] s, input logic cin);
      logic [7:0] y;
      logic [8:0] t;
      res_t       q;
      if (!m) y = 8'h00;
      else begin
         case (s)
            AE_ONES: y = 8'hFF;
            AE_B:    y = b;
            AE_NB:   y = ~b;
            default: y = 8'h00;
         endcase
      end
      t   = {1'b0, a} + {1'b0, y} + {8'h00, cin};
      q.r = t[7:0];
      q.c = t[8];
      q.z = (t[7:0] == 8'h00);
      q.o = (a[7] == y[7]) && (t[7] != a[7]);
      return q;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                         input logic m_v, input logic [1:0] s_v, input logic cin_v,
                         input logic [7:0] er, input logic ec, input logic ez, input logic eo);
      int   cyc;
      logic busy_ok;
      logic got;
      @(negedge clk);
      bus.a = a_v; bus.b = b_v; bus.m = m_v; bus.s = s_v; bus.cin = cin_v;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      // Scramble operands while busy: the op must use what was latched.
      bus.a = ~a_v; bus.b = ~b_v; bus.m = ~m_v; bus.s = ~s_v; bus.cin = ~cin_v;
      busy_ok = bus.busy;
      got     = 1'b0;
      cyc     = 0;
      while (!got && cyc < 20) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (bus.done) got = 1'b1;
         else if (!bus.busy) busy_ok = 1'b0;
      end
      check({tag, " latency"}, cyc, 8);
      check({tag, " busy"}, {31'd0, busy_ok}, 1);
      check({tag, " busy_at_done"}, {31'd0, bus.busy}, 0);
      check({tag, " result"}, {24'd0, bus.result}, {24'd0, er});
      check({tag, " cout"}, {31'd0, bus.cout}, {31'd0, ec});
      check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, ez});
      check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " busy"}, {31'd0, bus.busy}, 0);
      check({tag, " done"}, {31'd0, bus.done}, 0);
      check({tag, " result"}, {24'd0, bus.result}, 0);
      check({tag, " cout"}, {31'd0, bus.cout}, 0);
      check({tag, " zero"}, {31'd0, bus.zero}, 1);
      check({tag, " ovf"}, {31'd0, bus.ovf}, 0);
   endtask

   vec_t vecs[8];

   initial begin
      int         n_done;
      int         d_at[2];
      logic [7:0] d_res[2];
      logic       conflict;
      logic       got;
      res_t       q;

      vecs[0] = '{8'h3C, 8'h0F, 1'b1, AE_B,    1'b0, 8'h4B, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h10, 8'h20, 1'b1, AE_NB,   1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 1'b1, AE_NB,   1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{8'h7F, 8'h01, 1'b1, AE_B,    1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'h01, 8'hFF, 1'b1, AE_B,    1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 8'h5A, 1'b1, AE_ONES, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{8'hFF, 8'h33, 1'b1, AE_ZERO, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{8'h55, 8'hAA, 1'b0, AE_B,    1'b0, 8'h55, 1'b0, 1'b0, 1'b0};

      bus.start = 1'b0; bus.m = 1'b0; bus.s = 2'b00; bus.cin = 1'b0;
      bus.a = 8'h00; bus.b = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].s, vecs[i].cin,
                vecs[i].er, vecs[i].ec, vecs[i].ez, vecs[i].eo);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra, rb;
         logic       rm, rc;
         logic [1:0] rs;
         ra = 8'($urandom); rb = 8'($urandom);
         rm = ($urandom_range(0, 3) != 0);
         rs = 2'($urandom); rc = 1'($urandom);
         q  = model(ra, rb, rm, rs, rc);
         run_op($sformatf("rand%0d", i), ra, rb, rm, rs, rc, q.r, q.c, q.z, q.o);
      end

      // start held high for 20 cycles, with a changing mid-operation
      @(negedge clk);
      bus.a = 8'h10; bus.b = 8'h20; bus.m = 1'b1; bus.s = AE_B; bus.cin = 1'b0;
      bus.start = 1'b1;
      n_done = 0; conflict = 1'b0;
      d_at[0] = -1; d_at[1] = -1; d_res[0] = 8'h00; d_res[1] = 8'h00;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) begin
            if (n_done < 2) begin
               d_at[n_done]  = k;
               d_res[n_done] = bus.result;
            end
            n_done++;
            if (bus.busy) conflict = 1'b1;
         end
         if (k == 2)  bus.a = 8'h77;
         if (k == 11) bus.a = 8'h01;
      end
      bus.start = 1'b0;
      check("hold n_done", n_done, 2);
      check("hold first_done", d_at[0], 8);
      check("hold gap", d_at[1] - d_at[0], 9);
      check("hold res0", {24'd0, d_res[0]}, 32'h30);
      check("hold res1", {24'd0, d_res[1]}, 32'h97);
      check("hold busy_done", {31'd0, conflict}, 0);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (bus.done) got = 1'b1;
      end
      check("hold third_done", {31'd0, got}, 1);
      check("hold res2", {24'd0, bus.result}, 32'h21);

      // a start pulse during SHIFT must not queue a second operation
      @(negedge clk);
      bus.a = 8'h05; bus.b = 8'h03; bus.s = AE_B; bus.cin = 1'b0; bus.start = 1'b1;
      n_done = 0;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = (k == 3);
         if (bus.done) n_done++;
      end
      check("pulse n_done", n_done, 1);
      check("pulse idle", {31'd0, bus.busy}, 0);
      check("pulse result", {24'd0, bus.result}, 32'h08);

      // asynchronous reset part-way through an add
      run_op("pre_rst", 8'h3C, 8'h0F, 1'b1, AE_B, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.a = 8'h11; bus.b = 8'h22; bus.s = AE_B; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("midrst no_done", n_done, 0);
      run_op("post_rst", 8'h11, 8'h22, 1'b1, AE_B, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
